synth_cmd_decoder: RTL and testbench

SYNTH_CMD_DECODER -- requirements
Module: synth_cmd_decoder

---
 rtl/synth_cmd_decoder.sv | 106 ++++++++++
 tb/tb_synth_cmd_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/synth_cmd_decoder.sv
// synth_cmd_decoder: polls an SPI master every POLL_PERIOD cycles and decodes the returned command word.
// Define SYNTH_CMD_CHECKSUM_EN to enforce the word[7:0] XOR checksum; otherwise only the opcode is checked.
module synth_cmd_decoder #(
   parameter int POLL_PERIOD = 1000,
   parameter int TIMEOUT     = 256
) (
   input  logic        clk,
   input  logic        rstn,
   output logic        spi_rstn,
   output logic        spi_start,
   input  logic        spi_done,
   input  logic [31:0] spi_data,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [3:0]  cmd_op,
   output logic [3:0]  cmd_chan,
   output logic [15:0] cmd_data,
   output logic [7:0]  err_cnt,
   output logic        timeout
);
   localparam int PW = $clog2(POLL_PERIOD);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [2:0] IDLE = 3'd0, SRST = 3'd1, START = 3'd2, WAIT = 3'd3, DECODE = 3'd4, OUTPUT = 3'd5;
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
   logic [2:0]    state_q, state_d;
   logic [PW-1:0] poll_q, poll_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [31:0]   word_q, word_d;
   logic [23:0]   cmd_q, cmd_d;
   logic [7:0]    err_q, err_d;
   logic          to_q, to_d;
   logic [3:0]    op;
   logic          chk_ok, accept, reject;
   assign op = word_q[31:28];
`ifdef SYNTH_CMD_CHECKSUM_EN
   assign chk_ok = word_q[7:0] == (word_q[31:24] ^ word_q[23:16] ^ word_q[15:8]);
`else
   logic unused_chk;
   assign unused_chk = ^word_q[7:0];
   assign chk_ok = 1'b1;
`endif
   assign accept = op != 4'h0 && op < 4'h4 && chk_ok;
   assign reject = state_q == DECODE && op != 4'h0 && !accept;
   // poll_cnt runs in every state and saturates, so a poll missed while busy is issued once on return
   always_comb begin
      state_d = state_q;
      poll_d  = (poll_q == POLL_LAST) ? poll_q : poll_q + 1'b1;
      tcnt_d  = '0;
      word_d  = word_q;
      to_d    = 1'b0;
      case (state_q)
         IDLE: if (poll_q == POLL_LAST) begin
            state_d = SRST;
            poll_d  = '0;
         end
         SRST:  state_d = START;
         START: state_d = WAIT;
         WAIT: begin
            tcnt_d = tcnt_q + 1'b1;
            if (spi_done) begin
               word_d  = spi_data;
               state_d = DECODE;
            end else if (tcnt_q == TO_LAST) begin
               to_d    = 1'b1;
               state_d = IDLE;
            end
         end
         DECODE: state_d = accept ? OUTPUT : IDLE;
         OUTPUT: if (cmd_ready) begin
            state_d = (poll_q == POLL_LAST) ? SRST : IDLE;
            poll_d  = (poll_q == POLL_LAST) ? '0 : poll_d;
         end
         default: state_d = IDLE;
      endcase
   end
   assign cmd_d = (state_q == DECODE && accept) ? word_q[31:8] : cmd_q;
   assign err_d = ((to_d || reject) && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         poll_q  <= '0;
         tcnt_q  <= '0;
         word_q  <= '0;
         cmd_q   <= '0;
         err_q   <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         poll_q  <= poll_d;
         tcnt_q  <= tcnt_d;
         word_q  <= word_d;
         cmd_q   <= cmd_d;
         err_q   <= err_d;
         to_q    <= to_d;
      end
   end
   assign spi_rstn  = rstn && state_q != SRST;
   assign spi_start = state_q == START;
   assign cmd_valid = state_q == OUTPUT;
   assign cmd_op    = cmd_q[23:20];
   assign cmd_chan  = cmd_q[19:16];
   assign cmd_data  = cmd_q[15:0];
   assign err_cnt   = err_q;
   assign timeout   = to_q;
endmodule

// File: tb/tb_synth_cmd_decoder.sv
// tb_synth_cmd_decoder: timeline model of polls, responses and decode results, compared every cycle.
module tb_synth_cmd_decoder;
   localparam int P = 64, TO = 20, N = 32768;
`ifdef SYNTH_CMD_CHECKSUM_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   logic clk = 1'b0, rstn = 1'b0, spi_done = 1'b0, cmd_ready = 1'b0;
   logic [31:0] spi_data = '0;
   logic spi_rstn, spi_start, cmd_valid, timeout;
   logic [3:0] cmd_op, cmd_chan;
   logic [15:0] cmd_data;
   logic [7:0] err_cnt;
   int cyc = 0, n_tests = 0, n_fail = 0, next_poll = 0, t_ev = 0;
   bit m_srst[N], m_start[N], m_to[N], m_valid[N], m_err[N], m_rst[N], m_cmd[N];
   logic [23:0] m_cmdv[N];
   logic [7:0] e_err = '0;
   logic [23:0] e_cmd = '0;
   synth_cmd_decoder #(.POLL_PERIOD(P), .TIMEOUT(TO)) dut (
      .clk(clk), .rstn(rstn), .spi_rstn(spi_rstn), .spi_start(spi_start),
      .spi_done(spi_done), .spi_data(spi_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_chan(cmd_chan), .cmd_data(cmd_data), .err_cnt(err_cnt), .timeout(timeout)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (cyc > 0 && cyc < N) begin
         if (m_rst[cyc]) begin
            e_err = '0;
            e_cmd = '0;
         end
         if (m_err[cyc] && e_err != 8'hFF) e_err = e_err + 8'd1;
         if (m_cmd[cyc]) e_cmd = m_cmdv[cyc];
         check("spi_rstn", {31'd0, spi_rstn}, {31'd0, rstn && !m_srst[cyc]});
         check("spi_start", {31'd0, spi_start}, {31'd0, m_start[cyc]});
         check("cmd_valid", {31'd0, cmd_valid}, {31'd0, m_valid[cyc]});
         check("timeout", {31'd0, timeout}, {31'd0, m_to[cyc]});
         check("err_cnt", {24'd0, err_cnt}, {24'd0, e_err});
         check("cmd_fields", {8'd0, cmd_op, cmd_chan, cmd_data}, {8'd0, e_cmd});
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_cyc(input int t);
      while (cyc < t && cyc < N - 1) step();
   endtask
   task automatic mark_poll(output int tp);
      tp = next_poll;
      m_srst[tp] = 1'b1;
      m_start[tp + 1] = 1'b1;
      next_poll = tp + P;
   endtask
   task automatic premark();
      m_srst[next_poll] = 1'b1;
      m_start[next_poll + 1] = 1'b1;
   endtask
   // dly < 0: no response (timeout); otherwise spi_done dly cycles into WAIT; hold = valid cycles before ready
   task automatic txn(input logic [31:0] w, input int dly, input int hold);
      int tp, td, ta;
      logic [3:0] op;
      bit ok;
      mark_poll(tp);
      if (dly < 0) begin
         t_ev = tp + 2 + TO;
         m_to[t_ev] = 1'b1;
         m_err[t_ev] = 1'b1;
         premark();
         wait_cyc(t_ev);
         return;
      end
      td = tp + 2 + dly;
      t_ev = td + 2;
      ta = t_ev + hold;
      op = w[31:28];
      ok = (op >= 4'd1 && op <= 4'd3) && (!CHK || w[7:0] == (w[31:24] ^ w[23:16] ^ w[15:8]));
      if (ok) begin
         m_cmd[t_ev] = 1'b1;
         m_cmdv[t_ev] = w[31:8];
         for (int c = t_ev; c <= ta; c++) m_valid[c] = 1'b1;
         if (ta + 1 > next_poll) next_poll = ta + 1;
      end else if (op != 4'd0) m_err[t_ev] = 1'b1;
      premark();
      wait_cyc(td);
      spi_done = 1'b1;
      spi_data = w;
      step();
      spi_done = 1'b0;
      spi_data = $urandom;
      if (ok) begin
         wait_cyc(ta);
         cmd_ready = 1'b1;
         step();
         cmd_ready = 1'b0;
      end else wait_cyc(t_ev);
   endtask
   task automatic do_reset(input int hold);
      int x;
      x = cyc;
      rstn = 1'b0;
      spi_done = 1'b0;
      cmd_ready = 1'b0;
      for (int c = x + 1; c < N && c <= x + 2 * P + TO; c++) begin
         m_srst[c] = 1'b0; m_start[c] = 1'b0; m_to[c] = 1'b0; m_valid[c] = 1'b0;
         m_err[c] = 1'b0; m_cmd[c] = 1'b0; m_rst[c] = (c <= x + hold);
      end
      repeat (hold) step();
      rstn = 1'b1;
      next_poll = cyc + P;
   endtask
   initial begin
      int tp;
      do_reset(4);
      check("rst_err", {24'd0, err_cnt}, 32'd0);
      check("rst_start", {31'd0, spi_start}, 32'd0);
      check("rst_valid", {31'd0, cmd_valid}, 32'd0);
      for (int k = 1; k <= 3; k++) begin
         txn(32'h0, -1, 0);
         check("to_pulse", {31'd0, timeout}, 32'd1);
         check("to_err", {24'd0, err_cnt}, k);
      end
      txn(32'h13407F2C, 3, 0);
      check("note_on_op", {28'd0, cmd_op}, 32'd1);
      check("note_on_chan", {28'd0, cmd_chan}, 32'd3);
      check("note_on_data", {16'd0, cmd_data}, 32'h407F);
      check("note_on_clear", {31'd0, cmd_valid}, 32'd0);
      check("note_on_err", {24'd0, err_cnt}, 32'd3);
      txn(32'h13407F00, 5, 1);
      check("badchk_err", {24'd0, err_cnt}, CHK ? 32'd4 : 32'd3);
      check("badchk_data", {16'd0, cmd_data}, 32'h407F);
      txn(32'h00000000, 2, 0);
      check("noop_err", {24'd0, err_cnt}, CHK ? 32'd4 : 32'd3);
      spi_done = 1'b1;
      spi_data = 32'h2A12340C;
      step();
      spi_done = 1'b0;
      txn(32'h50000050, 0, 0);
      check("op5_err", {24'd0, err_cnt}, CHK ? 32'd5 : 32'd4);
      txn(32'h2A12340C, 1, 2);
      check("note_off_chan", {28'd0, cmd_chan}, 32'hA);
      txn(32'h3FFF00C0, TO - 1, 0);
      check("param_data", {16'd0, cmd_data}, 32'hFF00);
      txn(32'h13407F2C, 1, 3 * P);
      check("late_poll_srst", {31'd0, spi_rstn}, 32'd0);
      txn(32'h11000011, 0, 0);
      mark_poll(tp);
      wait_cyc(tp + 5);
      do_reset(3);
      check("midwait_err", {24'd0, err_cnt}, 32'd0);
      check("midwait_op", {28'd0, cmd_op}, 32'd0);
      for (int i = 0; i < 300; i++) txn((i % 2 == 0) ? 32'h50000050 : 32'hF0000000, i % 4, 0);
      check("err_sat", {24'd0, err_cnt}, 32'hFF);
      txn(32'h0, -1, 0);
      check("err_sat_to", {24'd0, err_cnt}, 32'hFF);
      do_reset(2);
      check("final_rst_err", {24'd0, err_cnt}, 32'd0);
      check("final_rst_data", {16'd0, cmd_data}, 32'd0);
      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
   initial begin
      #(N * 10);
      $display("FAIL watchdog: cycle budget of %0d exhausted", N);
      $fatal(1);
   end
endmodule
